// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : coin_acceptor
// Brief    : Two-slot coin sensor front end: synchronise, debounce, arbitrate,
//            and queue qualified coins for a downstream consumer.
// Revision : 1.0 - initial release
// ============================================================================
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sense5,
    input  logic       sense10,
    input  logic       take,
    output logic [1:0] coin,
    output logic       coin_valid,
    output logic       reject,
    output logic       full,
    output logic [7:0] total
);

    localparam int                    C_ADDR_W   = $clog2(FIFO_DEPTH);
    localparam int                    C_CNT_W    = C_ADDR_W + 1;
    localparam logic [3:0]            C_DEB      = DEBOUNCE_CYCLES[3:0];
    localparam logic [C_ADDR_W-1:0]   C_PTR_ONE  = C_ADDR_W'(1);
    localparam logic [C_CNT_W-1:0]    C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0]    C_DEPTH    = C_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } deb_state_t;

    // Bit 0 is the 5-rupee slot, bit 1 the 10-rupee slot.
    logic [1:0] w_sense_raw;
    logic [1:0] w_qualify;
    logic [1:0] w_busy;

    assign w_sense_raw = {sense10, sense5};

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic       sync1_q;
        logic       sync2_q;
        deb_state_t state_q;
        deb_state_t state_d;
        logic [3:0] cnt_q;
        logic [3:0] cnt_d;
        logic       w_qual;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= IDLE;
                cnt_q   <= 4'd0;
            end else begin
                sync1_q <= w_sense_raw[i];
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            w_qual  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_d = ARMING;
                        cnt_d   = 4'd1;
                    end
                end
                ARMING: begin
                    if (!sync2_q) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else if (cnt_q + 4'd1 == C_DEB) begin
                        w_qual  = 1'b1;
                        state_d = HELD;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                HELD: begin
                    if (!sync2_q) begin
                        state_d = RELEASING;
                        cnt_d   = 4'd1;
                    end
                end
                RELEASING: begin
                    if (sync2_q) begin
                        state_d = HELD;
                        cnt_d   = 4'd0;
                    end else if (cnt_q + 4'd1 == C_DEB) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        assign w_qualify[i] = w_qual;
        assign w_busy[i]    = (state_q != IDLE);
    end

    logic [FIFO_DEPTH-1:0][1:0] mem_q;
    logic [FIFO_DEPTH-1:0][1:0] mem_d;
    logic [C_ADDR_W-1:0]        wr_ptr_q;
    logic [C_ADDR_W-1:0]        wr_ptr_d;
    logic [C_ADDR_W-1:0]        rd_ptr_q;
    logic [C_ADDR_W-1:0]        rd_ptr_d;
    logic [C_CNT_W-1:0]         count_q;
    logic [C_CNT_W-1:0]         count_d;
    logic                       coin_valid_q;
    logic                       coin_valid_d;
    logic                       full_q;
    logic                       full_d;
    logic                       reject_q;
    logic                       reject_d;
    logic [7:0]                 total_q;
    logic [7:0]                 total_d;

    logic                       w_conflict;
    logic                       w_any_qual;
    logic                       w_pop;
    logic                       w_push;
    logic [1:0]                 w_push_code;
    logic [C_CNT_W-1:0]         w_count_after_pop;

    // A coin is ambiguous if the other slot is active at all, not only when
    // it qualifies on the same edge.
    assign w_conflict  = (w_qualify[0] & w_busy[1]) | (w_qualify[1] & w_busy[0]);
    assign w_any_qual  = |w_qualify;
    assign w_push_code = w_qualify[1] ? 2'b10 : 2'b01;
    assign w_pop       = take & coin_valid_q;
    assign w_push      = w_any_qual & ~w_conflict & ((count_q != C_DEPTH) | w_pop);
    assign w_count_after_pop = count_q - (w_pop ? C_CNT_ONE : '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        total_d  = total_q;
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        if (w_push) begin
            mem_d[wr_ptr_q] = w_push_code;
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
            if (total_q != 8'hFF) begin
                total_d = total_q + 8'd1;
            end
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
        // An entry written on this edge becomes visible one edge later.
        coin_valid_d = (w_count_after_pop != '0);
        full_d       = (count_d == C_DEPTH);
        reject_d     = w_any_qual & ~w_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            coin_valid_q <= 1'b0;
            full_q       <= 1'b0;
            reject_q     <= 1'b0;
            total_q      <= 8'd0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            coin_valid_q <= coin_valid_d;
            full_q       <= full_d;
            reject_q     <= reject_d;
            total_q      <= total_d;
        end
    end

    assign coin       = coin_valid_q ? mem_q[rd_ptr_q] : 2'b00;
    assign coin_valid = coin_valid_q;
    assign full       = full_q;
    assign reject     = reject_q;
    assign total      = total_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_acceptor
// Brief    : Self-checking bench for coin_acceptor with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       sense5  = 1'b0;
    logic       sense10 = 1'b0;
    logic       take    = 1'b0;
    logic [1:0] coin;
    logic       coin_valid;
    logic       reject;
    logic       full;
    logic [7:0] total;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int rej_seen = 0;
    int cv_seen  = 0;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sense5     (sense5),
        .sense10    (sense10),
        .take       (take),
        .coin       (coin),
        .coin_valid (coin_valid),
        .reject     (reject),
        .full       (full),
        .total      (total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: each slot is described by run lengths of its
    // two-edge-delayed samples and a "coin recognised" latch.
    typedef struct {
        logic [1:0] code;
        int         edge_no;
    } entry_t;

    entry_t mq[$];
    bit     m_h1[2];
    bit     m_h2[2];
    int     m_hrun[2];
    int     m_lrun[2];
    bit     m_latched[2];
    int     m_total;
    bit     m_reject;
    int     n_edges = 0;

    always @(posedge clk or posedge reset) begin : model
        bit         s;
        bit         pop;
        bit         push;
        bit         conflict;
        bit         qual[2];
        bit         busy[2];
        bit         raw[2];
        int         nq;
        logic [1:0] code;
        if (reset) begin
            mq.delete();
            m_total  = 0;
            m_reject = 0;
            for (int i = 0; i < 2; i++) begin
                m_h1[i] = 0; m_h2[i] = 0; m_hrun[i] = 0; m_lrun[i] = 0; m_latched[i] = 0;
            end
        end else begin
            raw[0] = sense5;
            raw[1] = sense10;
            pop = 0;
            if (take && mq.size() > 0)
                pop = (mq[0].edge_no < n_edges);
            for (int i = 0; i < 2; i++) begin
                busy[i] = m_latched[i] || (m_hrun[i] > 0);
                s = m_h2[i];
                m_h2[i] = m_h1[i];
                m_h1[i] = raw[i];
                if (s) begin m_hrun[i]++; m_lrun[i] = 0; end
                else   begin m_lrun[i]++; m_hrun[i] = 0; end
                qual[i] = !m_latched[i] && s && (m_hrun[i] == DEB);
                if (qual[i])                              m_latched[i] = 1;
                else if (m_latched[i] && m_lrun[i] == DEB) m_latched[i] = 0;
            end
            nq       = int'(qual[0]) + int'(qual[1]);
            conflict = (qual[0] && busy[1]) || (qual[1] && busy[0]);
            code     = qual[1] ? 2'b10 : 2'b01;
            push     = 0;
            m_reject = 0;
            if (nq > 0) begin
                if (conflict)                        m_reject = 1;
                else if (mq.size() == DEPTH && !pop) m_reject = 1;
                else                                 push = 1;
            end
            n_edges++;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{code: code, edge_no: n_edges});
                if (m_total < 255) m_total++;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ev;
        int ec;
        if (reject === 1'b1)     rej_seen++;
        if (coin_valid === 1'b1) cv_seen++;
        if (cmp_en) begin
            ev = 0;
            ec = 0;
            if (mq.size() > 0) ev = (mq[0].edge_no < n_edges);
            if (ev) ec = int'(mq[0].code);
            chk("coin_valid", int'(coin_valid), int'(ev));
            chk("coin", int'(coin), ec);
            chk("reject", int'(reject), int'(m_reject));
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("total", int'(total), m_total);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; sense5 = 0; sense10 = 0; take = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    // line 0 = 5, 1 = 10, 2 = both; take_at > 0 raises take for that edge only.
    task automatic coin_event(input int line, input int hi, input int lo, input int take_at);
        if (line != 1) sense5  = 1;
        if (line != 0) sense10 = 1;
        for (int k = 1; k <= hi + lo; k++) begin
            @(posedge clk); #1;
            if (k == hi) begin sense5 = 0; sense10 = 0; end
            if (take_at > 0) take = (k == take_at - 1);
        end
    endtask

    initial begin : stim
        int first;
        int cvn;
        int code;
        int r0;
        int c0;
        int seq[4];
        bit found;

        @(posedge clk);
        cmp_en = 1;
        @(posedge clk); #1;
        chk("rst_coin", int'(coin), 0);
        chk("rst_valid", int'(coin_valid), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_total", int'(total), 0);
        reset = 0;

        // Single 5 coin with take held high
        take = 1; sense5 = 1; first = 0; cvn = 0; code = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 10) sense5 = 0;
            if (coin_valid) begin
                cvn++;
                if (first == 0) begin first = k; code = int'(coin); end
            end
        end
        chk("s1_latency", first, 7);
        chk("s1_valid_cycles", cvn, 1);
        chk("s1_code", code, 1);
        chk("s1_total", int'(total), 1);

        // Short glitch on the 10 slot
        do_reset();
        r0 = rej_seen; c0 = cv_seen;
        coin_event(1, 3, 12, -1);
        chk("s2_valid", cv_seen - c0, 0);
        chk("s2_reject", rej_seen - r0, 0);
        chk("s2_total", int'(total), 0);

        // Both slots together
        do_reset();
        r0 = rej_seen; c0 = cv_seen;
        coin_event(2, 8, 10, -1);
        chk("s3_reject", rej_seen - r0, 1);
        chk("s3_valid", cv_seen - c0, 0);
        chk("s3_total", int'(total), 0);

        // Fill the queue, overflow, then drain
        do_reset();
        r0 = rej_seen;
        for (int i = 0; i < 5; i++) coin_event(i % 2, 6, 8, -1);
        chk("s4_full", int'(full), 1);
        chk("s4_total", int'(total), 4);
        chk("s4_reject", rej_seen - r0, 1);
        take = 1;
        seq[0] = int'(coin);
        for (int j = 1; j < 4; j++) begin @(posedge clk); #1; seq[j] = int'(coin); end
        @(posedge clk); #1;
        chk("s4_seq0", seq[0], 1);
        chk("s4_seq1", seq[1], 2);
        chk("s4_seq2", seq[2], 1);
        chk("s4_seq3", seq[3], 2);
        chk("s4_empty", int'(coin_valid), 0);
        take = 0;

        // Push into a full queue while popping
        do_reset();
        coin_event(0, 6, 8, -1);
        coin_event(1, 6, 8, -1);
        coin_event(0, 6, 8, -1);
        coin_event(0, 6, 8, -1);
        r0 = rej_seen;
        coin_event(1, 6, 8, 6);
        chk("s5_full", int'(full), 1);
        chk("s5_reject", rej_seen - r0, 0);
        chk("s5_total", int'(total), 5);
        take = 1;
        seq[0] = int'(coin);
        for (int j = 1; j < 4; j++) begin @(posedge clk); #1; seq[j] = int'(coin); end
        take = 0;
        chk("s5_seq0", seq[0], 2);
        chk("s5_seq1", seq[1], 1);
        chk("s5_seq2", seq[2], 1);
        chk("s5_tail", seq[3], 2);

        // Reset mid-queue and mid-debounce
        do_reset();
        coin_event(0, 6, 8, -1);
        coin_event(1, 6, 8, -1);
        sense5 = 1;
        repeat (4) @(posedge clk);
        #1 reset = 1;
        #1;
        chk("s6_valid", int'(coin_valid), 0);
        chk("s6_total", int'(total), 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        first = 0; found = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(posedge clk); #1;
            if (coin_valid) begin found = 1; first = k; end
        end
        chk("s6_latency", first, 7);
        chk("s6_code", int'(coin), 1);
        sense5 = 0;
        repeat (12) @(posedge clk);
        #1;

        // Saturate the pushed-coin count
        do_reset();
        take = 1;
        for (int i = 0; i < 260; i++) coin_event(i % 2, 5, 6, -1);
        chk("s7_total_sat", int'(total), 255);
        chk("s7_full", int'(full), 0);
        take = 0;

        repeat (2) @(posedge clk);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
